// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : key_debouncer
//  Purpose  : Conditions raw board push-buttons / switches for synchronous
//             logic. Each channel is synchronised to CLOCK_50 and passed
//             through a stability counter. A new level is accepted only
//             after it has been seen for DEBOUNCE_CYCLES consecutive
//             synchronised samples. The clean level keeps the raw pin
//             polarity. One-cycle press/release strobes mark each acceptance.
//
//  Parameters
//    WIDTH           : number of independent channels
//    DEBOUNCE_CYCLES : consecutive stable samples needed to accept (>= 2)
//    ACTIVE_LOW      : 1 -> released/idle level is 1, 0 -> idle level is 0
//
//  Ports
//    CLOCK_50  in   1      system clock, rising edge
//    RST_N     in   1      synchronous active-low reset
//    KEY_RAW   in   WIDTH  asynchronous, bouncing pins
//    KEY_CLEAN out  WIDTH  debounced level, same polarity as KEY_RAW
//    PRESS     out  WIDTH  one-cycle strobe on acceptance of non-idle level
//    RELEASE   out  WIDTH  one-cycle strobe on acceptance of idle level
//
//  Revision : 1.0  initial release
// ============================================================================
module key_debouncer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] KEY_RAW,
  output logic [WIDTH-1:0] KEY_CLEAN,
  output logic [WIDTH-1:0] PRESS,
  output logic [WIDTH-1:0] RELEASE
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // Last count value. When the counter holds this value and the input still
  // disagrees, the current edge is the DEBOUNCE_CYCLES-th disagreeing sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan

    // The channel state is not stored separately. It is fully implied by
    // sync2 versus stable, and decoding it keeps the two views consistent.
    typedef enum logic [0:0] {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
    } state_t;

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press_q;
    logic             release_q;

    state_t           state;
    logic             stable_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Next-state / next-output logic
    always_comb begin
      state       = (sync2 == stable) ? ST_STABLE : ST_PENDING;
      stable_nxt  = stable;
      cnt_nxt     = '0;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;

      case (state)
        ST_STABLE: begin
          // Agreement discards any partial count, so a bounce that returns
          // to the accepted level never produces output activity.
          cnt_nxt = '0;
        end
        ST_PENDING: begin
          if (cnt == CNT_LAST) begin
            stable_nxt  = sync2;
            cnt_nxt     = '0;
            press_nxt   = (sync2 != IDLE);
            release_nxt = (sync2 == IDLE);
          end else begin
            // Cannot wrap: the counter is cleared at CNT_LAST or on agreement.
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          cnt_nxt = '0;
        end
      endcase
    end

    // Registers
    always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
        sync1     <= IDLE;
        sync2     <= IDLE;
        stable    <= IDLE;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        // Two-flop synchroniser for the asynchronous pin
        sync1     <= KEY_RAW[ch];
        sync2     <= sync1;
        stable    <= stable_nxt;
        cnt       <= cnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // All outputs come straight from flops.
    assign KEY_CLEAN[ch] = stable;
    assign PRESS[ch]     = press_q;
    assign RELEASE[ch]   = release_q;

  end : g_chan

endmodule : key_debouncer
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debouncer
//  Purpose  : Self-checking bench for key_debouncer (WIDTH=3,
//             DEBOUNCE_CYCLES=4, ACTIVE_LOW=1). Uses table vectors,
//             directed corner-case sequences and random stimulus. A
//             behavioural window model checks every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_debouncer;

  localparam int       W    = 3;
  localparam int       D    = 4;
  localparam logic     IDLE = 1'b1;
  localparam logic [W-1:0] ALL_IDLE = 3'b111;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] raw;
  logic [W-1:0] key_clean;
  logic [W-1:0] press;
  logic [W-1:0] release_s;

  int checks;
  int errors;

  key_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .KEY_RAW   (raw),
    .KEY_CLEAN (key_clean),
    .PRESS     (press),
    .RELEASE   (release_s)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: raw passes through a two-sample delay. A channel
  // accepts when its last D synchronised samples all differ from the
  // accepted level.
  // ---------------------------------------------------------------------
  logic [W-1:0] m_s1, m_s2, m_clean, m_press, m_rel;
  logic [W-1:0] m_win [D];

  task automatic model_edge(input logic [W-1:0] r, input logic rn);
    if (!rn) begin
      m_s1    = ALL_IDLE;
      m_s2    = ALL_IDLE;
      m_clean = ALL_IDLE;
      m_press = '0;
      m_rel   = '0;
      for (int j = 0; j < D; j++) m_win[j] = ALL_IDLE;
    end else begin
      for (int j = D - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_s2;
      m_press  = '0;
      m_rel    = '0;
      for (int c = 0; c < W; c++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (m_win[j][c] == m_clean[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_clean[c] = m_win[0][c];
          if (m_win[0][c] != IDLE) m_press[c] = 1'b1;
          else                     m_rel[c]   = 1'b1;
          // The accepted sample now matches the accepted level.
        end
      end
      m_s2 = m_s1;
      m_s1 = r;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: the model sees the inputs present at the edge, and the
  // DUT is sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(raw, rst_n);
    chk("model_clean",   {29'd0, key_clean}, {29'd0, m_clean});
    chk("model_press",   {29'd0, press},     {29'd0, m_press});
    chk("model_release", {29'd0, release_s}, {29'd0, m_rel});
    chk("strobe_excl",   {29'd0, press & release_s}, 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] prs;
    logic [W-1:0] rel;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [W-1:0] seen;
    int press_at, rel_at;
    logic [W-1:0] press_val, rel_val, clean_at_press;

    checks = 0;
    errors = 0;

    // Press / release of channel 0. Index 0 is edge E and index 7 is edge F.
    for (int i = 0; i < 14; i++) begin
      vecs[i].raw   = (i < 7) ? 3'b110 : 3'b111;
      vecs[i].clean = (i >= 5 && i < 12) ? 3'b110 : 3'b111;
      vecs[i].prs   = (i == 5)  ? 3'b001 : 3'b000;
      vecs[i].rel   = (i == 12) ? 3'b001 : 3'b000;
    end

    rst_n = 1'b0;
    raw   = 3'b111;

    // 1. Reset, then quiet idle
    for (int i = 0; i < 3; i++) tick();
    chk("reset_clean",   {29'd0, key_clean}, 32'h7);
    chk("reset_press",   {29'd0, press},     32'h0);
    chk("reset_release", {29'd0, release_s}, 32'h0);
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= press | release_s | ~key_clean;
    end
    chk("idle_quiet", {29'd0, seen}, 32'h0);

    // 2. Table-driven press / release
    for (int i = 0; i < 14; i++) begin
      raw = vecs[i].raw;
      tick();
      chk($sformatf("vec%0d_clean", i),   {29'd0, key_clean}, {29'd0, vecs[i].clean});
      chk($sformatf("vec%0d_press", i),   {29'd0, press},     {29'd0, vecs[i].prs});
      chk($sformatf("vec%0d_release", i), {29'd0, release_s}, {29'd0, vecs[i].rel});
    end
    for (int i = 0; i < 6; i++) tick();

    // 3. Bounce on channel 1 with a two-cycle period
    seen = '0;
    for (int i = 0; i < 30; i++) begin
      raw = {1'b1, ((i / 2) % 2 == 1) ? 1'b0 : 1'b1, 1'b1};
      tick();
      seen |= press | release_s | ~key_clean;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= press | release_s | ~key_clean;
    end
    chk("bounce_quiet", {29'd0, seen}, 32'h0);

    // 4a. Three-cycle low glitch on channel 2 is ignored.
    seen = '0;
    raw  = 3'b011;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) raw = 3'b111;
      tick();
      seen |= press | release_s | ~key_clean;
    end
    chk("glitch3_quiet", {29'd0, seen}, 32'h0);

    // 4b. Four-cycle low glitch is accepted, and release follows 4 cycles later.
    press_at = -1; rel_at = -1; press_val = '0; rel_val = '0;
    raw = 3'b011;
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) raw = 3'b111;
      tick();
      if (press != 0 && press_at < 0) begin press_at = k; press_val = press; end
      if (release_s != 0 && rel_at < 0) begin rel_at = k; rel_val = release_s; end
    end
    chk("glitch4_press_cycle", press_at, 6);
    chk("glitch4_press_val",   {29'd0, press_val}, 32'h4);
    chk("glitch4_rel_cycle",   rel_at, 10);
    chk("glitch4_rel_val",     {29'd0, rel_val},   32'h4);

    // 5. Simultaneous press on channels 0 and 2
    press_at = -1; press_val = '0; clean_at_press = '0;
    raw = 3'b010;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (press != 0 && press_at < 0) begin
        press_at = k; press_val = press; clean_at_press = key_clean;
      end
    end
    chk("dual_press_cycle", press_at, 6);
    chk("dual_press_val",   {29'd0, press_val},      32'h5);
    chk("dual_clean",       {29'd0, clean_at_press}, 32'h2);
    raw = 3'b111;
    for (int k = 0; k < 10; k++) tick();

    // 6. Reset while channel 0 holds its final count value
    raw = 3'b110;
    for (int k = 1; k <= 5; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("midcount_reset_clean",   {29'd0, key_clean}, 32'h7);
    chk("midcount_reset_press",   {29'd0, press},     32'h0);
    chk("midcount_reset_release", {29'd0, release_s}, 32'h0);
    rst_n = 1'b1;
    press_at = -1; press_val = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (press != 0 && press_at < 0) begin press_at = k; press_val = press; end
    end
    chk("post_reset_press_cycle", press_at, 6);
    chk("post_reset_press_val",   {29'd0, press_val}, 32'h1);
    raw = 3'b111;
    for (int k = 0; k < 10; k++) tick();

    // Random stimulus. Pins flip rarely enough for some changes to be accepted.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 4) == 0) raw[c] = ~raw[c];
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_debouncer
`default_nettype wire

// File: doc/key_debouncer.md
# key_debouncer

Input-conditioning stage between raw board push-buttons/switches and the simple I/O logic. It synchronizes each raw input to the system clock, rejects contact bounce with a per-channel stability counter, and presents a clean level in the same polarity as the raw pin. Its output drops directly into the downstream `KEY`/`SW` port. It also produces one-cycle press and release strobes for sequential consumers such as counters and FSMs.

## Interface
- `WIDTH`, 3: number of independent input channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz). Legal values are 2 or more.
- `ACTIVE_LOW`, 1: 1 means the idle/released level is 1 (board KEYs); 0 means the idle level is 0.

- `CLOCK_50`  in  1  system clock; all logic is on the rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `KEY_RAW`  in  WIDTH  asynchronous, bouncing pins.
- `KEY_CLEAN`  out  WIDTH  debounced level, same polarity as `KEY_RAW`.
- `PRESS`  out  WIDTH  one-cycle strobe when a channel becomes accepted as pressed (non-idle).
- `RELEASE`  out  WIDTH  one-cycle strobe when a channel becomes accepted as released (idle).

## Operation
- IDLE level is `ACTIVE_LOW ? 1 : 0`.
- Each channel is independent. No state is shared between channels, and there is no priority.
- Per channel, the following registers exist:
  - 2-flop synchronizer: `sync1` then `sync2`.
  - `stable` register, which drives `KEY_CLEAN`.
  - Counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - Registered `PRESS` and `RELEASE` bits.
- Each edge, the channel behaves as follows:
  - If `sync2 == stable`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `sync2` and `cnt` ← 0. Assert `PRESS` if the new value ≠ IDLE; otherwise assert `RELEASE`.
  - Else: `cnt` ← `cnt`+1.
  - `PRESS`/`RELEASE` are 0 on every edge where no acceptance occurs, so each strobe is exactly one cycle.
- Any return of `sync2` to `stable` before the count completes discards the partial count. A bounce therefore never produces output activity.
- The counter never wraps. It saturates by construction, because it resets on acceptance or on agreement.
- Equivalent two-state view per channel:
  - STABLE: `cnt` is 0 and `sync2 == stable`.
  - PENDING: `sync2 ≠ stable`, counting.
  - PENDING → STABLE happens on acceptance or on agreement.
- Reset (`RST_N` low at an edge):
  - `sync1`, `sync2` and `stable` ← IDLE.
  - `cnt` ← 0.
  - `PRESS` and `RELEASE` ← 0.
  - Reset overrides any in-progress count.
  - After reset, a pin already held active is accepted through the normal path and produces a `PRESS` strobe.

## Timing
- Reset values of outputs: `KEY_CLEAN` = all IDLE (e.g. 3'b111 for the defaults), `PRESS` = 0, `RELEASE` = 0.
- Latency: suppose raw changes before edge E and then holds.
  - `sync2` reflects the change after edge E+1.
  - `KEY_CLEAN` and the strobe change at edge E+1+`DEBOUNCE_CYCLES`.
  - Total: 2+`DEBOUNCE_CYCLES` edges counted from the first sampling edge E.
- Minimum accepted pulse: a raw level must persist for `DEBOUNCE_CYCLES` consecutive synchronized samples. Anything shorter by one or more cycles is rejected.
- Simultaneous changes on several channels are each accepted on their own schedule. Equal timing yields strobes in the same cycle (a multi-bit `PRESS`).
- `PRESS` and `RELEASE` are never both high on the same channel in the same cycle.
- All outputs come directly from registers. There is no combinational path from `KEY_RAW` to any output.

## Test plan
Use `WIDTH`=3, `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=1 throughout.

1. Hold `RST_N`=0 for 3 edges with `KEY_RAW`=3'b111, then release → `KEY_CLEAN`=3'b111, `PRESS`=0 and `RELEASE`=0 on every cycle for the next 20 cycles.
2. Change `KEY_RAW` 3'b111→3'b110 just before edge E and hold → `KEY_CLEAN`=3'b110 and `PRESS`=3'b001 after edge E+5 for exactly one cycle. Then restore 3'b111 before edge F → `RELEASE`=3'b001 after edge F+5 for one cycle.
3. Toggle `KEY_RAW[1]` every 2 cycles for 30 cycles, ending at 1 → `KEY_CLEAN`=3'b111 throughout, no `PRESS`/`RELEASE` activity.
4. Glitch boundary on `KEY_RAW[2]`:
   - 3-cycle low glitch → ignored.
   - 4-cycle low glitch → `PRESS`=3'b100 one cycle, then `RELEASE`=3'b100 exactly 4 cycles later.
5. Drive `KEY_RAW[0]` and `KEY_RAW[2]` low on the same edge → `PRESS`=3'b101 in a single cycle, `KEY_CLEAN`=3'b010.
6. Hold `KEY_RAW[0]`=0. Assert `RST_N`=0 for 1 edge when that channel's `cnt`=3 → `KEY_CLEAN`=3'b111 and no strobe.
   - Keep the pin held after reset release → `PRESS`=3'b001 after the 6th edge following release.
